// File: rtl/sar_compare_search.sv
// sar_compare_search: successive-approximation search driving an L/E/G comparator to recover an unknown target.
module sar_compare_search #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cmp_l,
    input  logic         cmp_e,
    input  logic         cmp_g,
    output logic [W-1:0] guess,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         exact,
    output logic         err
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, TRIAL, DONE} state_t;

    state_t        state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [W-1:0]  guess_n, result_n, d;
    logic          exact_n, err_n;

    assign busy = (state == TRIAL);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= IW'(W - 1);
            guess  <= '0;
            result <= '0;
            exact  <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            idx    <= idx_n;
            guess  <= guess_n;
            result <= result_n;
            exact  <= exact_n;
            err    <= err_n;
        end
    end

    // d is the guess with the bit under test resolved by the comparator verdict
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        guess_n  = guess;
        result_n = result;
        exact_n  = exact;
        err_n    = err;
        d        = cmp_g ? (guess & ~(W'(1) << idx)) : guess;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = TRIAL;
                    guess_n = W'(1) << (W - 1);
                    idx_n   = IW'(W - 1);
                    exact_n = 1'b0;
                    err_n   = 1'b0;
                end
            end
            TRIAL: begin
                if (!$onehot({cmp_l, cmp_e, cmp_g})) begin
                    state_n  = DONE;
                    guess_n  = '0;
                    result_n = '0;
                    exact_n  = 1'b0;
                    err_n    = 1'b1;
                end else if (cmp_e) begin
                    state_n  = DONE;
                    guess_n  = '0;
                    result_n = guess;
                    exact_n  = 1'b1;
                end else if (idx == '0) begin
                    state_n  = DONE;
                    guess_n  = '0;
                    result_n = d;
                    exact_n  = 1'b0;
                end else begin
                    guess_n = d | (W'(1) << (idx - IW'(1)));
                    idx_n   = idx - IW'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                guess_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sar_compare_search.sv
// tb_sar_compare_search: scoreboard bench; a behavioural comparator answers the DUT's guesses.
module tb_sar_compare_search;
    logic       clk = 1'b0;
    logic       rst, start, cmp_l, cmp_e, cmp_g, busy, done, exact, err;
    logic [2:0] guess, result, target;
    logic       force_bad;
    logic       bad;

    logic [2:0] gq[$];
    logic [4:0] rq[$];
    int checks = 0;
    int errors = 0;
    int dones  = 0;

    sar_compare_search #(.W(3)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cmp_l(cmp_l), .cmp_e(cmp_e), .cmp_g(cmp_g),
        .guess(guess), .busy(busy), .done(done),
        .result(result), .exact(exact), .err(err)
    );

    always #5 clk = ~clk;

    // forced fault makes L and G both assert on the chosen trial
    assign bad   = force_bad && (guess == 3'b010);
    assign cmp_l = bad | (guess < target);
    assign cmp_e = !bad & (guess == target);
    assign cmp_g = bad | (guess > target);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) begin
                if (gq.size() == 0) chk("guess_unexpected", 1, 0);
                else chk("guess", guess, gq.pop_front());
            end
            if (done) begin
                dones++;
                if (rq.size() == 0) chk("done_unexpected", 1, 0);
                else chk("result_exact_err", {result, exact, err}, rq.pop_front());
            end
        end
    end

    task automatic search(input logic [2:0] t, input int n, input bit hold);
        int c;
        target = t;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 if (!hold) start = 1'b0;
        chk("busy_at_start", busy, 1);
        chk("err_clear", err, 0);
        chk("exact_clear", exact, 0);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < 20);
        chk("latency", c, n + 1);
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        chk("idle_after", busy | done, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; target = 3'd0; force_bad = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_guess", guess, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_exact", exact, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;

        gq.push_back(3'd4); gq.push_back(3'd6); gq.push_back(3'd5);
        rq.push_back({3'd5, 1'b1, 1'b0});
        search(3'd5, 3, 1'b0);

        gq.push_back(3'd4); gq.push_back(3'd2); gq.push_back(3'd1);
        rq.push_back({3'd0, 1'b0, 1'b0});
        search(3'd0, 3, 1'b0);

        gq.push_back(3'd4);
        rq.push_back({3'd4, 1'b1, 1'b0});
        search(3'd4, 1, 1'b0);

        gq.push_back(3'd4); gq.push_back(3'd6); gq.push_back(3'd7);
        rq.push_back({3'd7, 1'b1, 1'b0});
        search(3'd7, 3, 1'b1);
        chk("held_start_ignored", busy, 0);

        force_bad = 1'b1;
        gq.push_back(3'd4); gq.push_back(3'd2);
        rq.push_back({3'd0, 1'b0, 1'b1});
        search(3'd2, 2, 1'b0);
        force_bad = 1'b0;

        gq.push_back(3'd4); gq.push_back(3'd2); gq.push_back(3'd1);
        rq.push_back({3'd1, 1'b1, 1'b0});
        search(3'd1, 3, 1'b0);

        // abort during the second trial; only the first guess is ever seen
        target = 3'd3;
        gq.push_back(3'd4);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("abort_guess", guess, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_exact", exact, 0);
        chk("abort_err", err, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        gq.push_back(3'd4); gq.push_back(3'd6);
        rq.push_back({3'd6, 1'b1, 1'b0});
        search(3'd6, 2, 1'b0);

        repeat (4) @(posedge clk);
        chk("guess_queue_empty", gq.size(), 0);
        chk("result_queue_empty", rq.size(), 0);
        chk("done_pulses", dones, 7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
